// File: rtl/droop_tap_calibrator_pkg.sv
// Shared definitions for the anti-droop tap calibrator: FSM encoding,
// tap-weight limits, accumulator width helper and trigger edge convention.
package droop_tap_calibrator_pkg;

  localparam int DIN_W = 16;
  localparam int TAPW_W = 7;
  localparam int TAPW_MAX = 63;
  localparam int TAPW_MIN = -64;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DELAY  = 3'd1;
  localparam logic [2:0] ST_WIN_A  = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_WIN_B  = 3'd4;
  localparam logic [2:0] ST_UPDATE = 3'd5;

  // Window sums grow by WIN_LOG2 bits so a full-scale window cannot overflow.
  function automatic int sum_width(input int win_log2);
    return DIN_W + win_log2;
  endfunction

  // Rising edge seen on the newer synchroniser stage but not yet on the older.
  function automatic logic trig_edge(input logic newer, input logic older);
    return newer & ~older;
  endfunction

endpackage

// File: rtl/droop_tap_calibrator_if.sv
// Sample/trigger/enable inputs and tap-weight/status outputs of the calibrator.
interface droop_tap_calibrator_if;
  import droop_tap_calibrator_pkg::*;

  logic                     trig;
  logic signed [DIN_W-1:0]  din;
  logic                     cal_en;
  logic signed [TAPW_W-1:0] tapWeight;
  logic                     cal_busy;
  logic                     cal_done;
  logic                     weight_sat;

  modport master (
    output trig, din, cal_en,
    input  tapWeight, cal_busy, cal_done, weight_sat
  );

  modport slave (
    input  trig, din, cal_en,
    output tapWeight, cal_busy, cal_done, weight_sat
  );

endinterface

// File: rtl/droop_window_acc.sv
// Signed window accumulator: sums din for 2^WIN_LOG2 enabled cycles,
// done is high on the cycle the last sample of the window is taken.
module droop_window_acc
  import droop_tap_calibrator_pkg::*;
#(
  parameter int WIN_LOG2 = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    clr,
  input  logic                                    en,
  input  logic signed [DIN_W-1:0]                 din,
  output logic signed [sum_width(WIN_LOG2)-1:0]   sum,
  output logic                                    done
);

  localparam int SW = sum_width(WIN_LOG2);

  logic signed [SW-1:0]   sum_reg;
  logic [WIN_LOG2-1:0]    cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg <= '0;
      cnt_reg <= '0;
    end else if (clr) begin
      sum_reg <= '0;
      cnt_reg <= '0;
    end else if (en) begin
      sum_reg <= sum_reg + SW'(din);
      cnt_reg <= cnt_reg + (WIN_LOG2)'(1);
    end
  end

  assign sum  = sum_reg;
  assign done = en && (cnt_reg == '1);

endmodule

// File: rtl/droop_tap_calibrator.sv
// Sign-sign tap calibrator: compares early/late window means of each pulse
// and nudges the IIR anti-droop tap weight by one LSB per pulse.
module droop_tap_calibrator
  import droop_tap_calibrator_pkg::*;
#(
  parameter int WIN_LOG2    = 4,
  parameter int DELAY       = 8,
  parameter int GAP         = 64,
  parameter int DEADBAND    = 32,
  parameter int INIT_WEIGHT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  droop_tap_calibrator_if.slave   cal
);

  localparam int SW = sum_width(WIN_LOG2);
  localparam int DW = SW + 1;
  localparam int CW = 16;
  localparam logic signed [DW-1:0]     DB_POS = DW'(DEADBAND);
  localparam logic signed [DW-1:0]     DB_NEG = DW'(-DEADBAND);
  localparam logic signed [TAPW_W-1:0] W_MAX  = TAPW_W'(TAPW_MAX);
  localparam logic signed [TAPW_W-1:0] W_MIN  = TAPW_W'(TAPW_MIN);
  localparam logic signed [TAPW_W-1:0] W_INIT = TAPW_W'(INIT_WEIGHT);

  logic                     trig_a, trig_b, trig_rise;
  logic [2:0]               state_reg, state_next;
  logic [CW-1:0]            cnt_reg;
  logic signed [TAPW_W-1:0] tapw_reg;
  logic                     sat_reg;
  logic                     clr_acc;
  logic [1:0]               en_w, done_w;
  logic signed [SW-1:0]     sum_w [2];
  logic signed [DW-1:0]     diff_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_a <= 1'b0;
      trig_b <= 1'b0;
    end else begin
      trig_a <= cal.trig;
      trig_b <= trig_a;
    end
  end

  assign trig_rise = trig_edge(trig_a, trig_b);
  assign clr_acc   = (state_reg == ST_IDLE) && trig_rise && cal.cal_en;
  assign en_w[0]   = (state_reg == ST_WIN_A) && cal.cal_en;
  assign en_w[1]   = (state_reg == ST_WIN_B) && cal.cal_en;

  // Window A (early) is instance 0, window B (late) is instance 1.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_win
      droop_window_acc #(.WIN_LOG2(WIN_LOG2)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_acc),
        .en    (en_w[gi]),
        .din   (cal.din),
        .sum   (sum_w[gi]),
        .done  (done_w[gi])
      );
    end
  endgenerate

  assign diff_w = DW'(sum_w[1]) - DW'(sum_w[0]);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (trig_rise && cal.cal_en) state_next = (DELAY == 0) ? ST_WIN_A : ST_DELAY;
      ST_DELAY:  if (cnt_reg == CW'(DELAY - 1)) state_next = ST_WIN_A;
      ST_WIN_A:  if (done_w[0]) state_next = (GAP == 0) ? ST_WIN_B : ST_GAP;
      ST_GAP:    if (cnt_reg == CW'(GAP - 1)) state_next = ST_WIN_B;
      ST_WIN_B:  if (done_w[1]) state_next = ST_UPDATE;
      ST_UPDATE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    // Dropping enable aborts whatever measurement is running.
    if (!cal.cal_en && state_reg != ST_IDLE) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg)
        cnt_reg <= '0;
      else if (state_reg == ST_DELAY || state_reg == ST_GAP)
        cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // Late window lower than early window means residual droop: raise the tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tapw_reg <= W_INIT;
      sat_reg  <= 1'b0;
    end else if (state_reg == ST_UPDATE && cal.cal_en) begin
      if (diff_w < DB_NEG) begin
        if (tapw_reg == W_MAX) sat_reg  <= 1'b1;
        else                   tapw_reg <= tapw_reg + TAPW_W'(1);
      end else if (diff_w > DB_POS) begin
        if (tapw_reg == W_MIN) sat_reg  <= 1'b1;
        else                   tapw_reg <= tapw_reg - TAPW_W'(1);
      end
    end
  end

  assign cal.tapWeight  = tapw_reg;
  assign cal.cal_busy   = (state_reg != ST_IDLE);
  assign cal.cal_done   = (state_reg == ST_UPDATE) && cal.cal_en;
  assign cal.weight_sat = sat_reg;

endmodule

// File: tb/tb_droop_tap_calibrator.sv
// Directed bench: three calibrators (INIT_WEIGHT 0, 62, -63) share one stimulus.
module tb_droop_tap_calibrator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               trig;
  logic signed [15:0] din;
  logic               cal_en;
  int                 din_mode;   // 0 hold, 1 falling ramp, 2 rising ramp
  int                 n_tests = 0;
  int                 n_fail = 0;
  int                 lat, ndone, busy1, cnt;

  always #5 clk = ~clk;

  droop_tap_calibrator_if if0 ();
  droop_tap_calibrator_if if1 ();
  droop_tap_calibrator_if if2 ();

  assign if0.trig = trig;  assign if0.din = din;  assign if0.cal_en = cal_en;
  assign if1.trig = trig;  assign if1.din = din;  assign if1.cal_en = cal_en;
  assign if2.trig = trig;  assign if2.din = din;  assign if2.cal_en = cal_en;

  droop_tap_calibrator #(.INIT_WEIGHT(0))   dut0 (.clk(clk), .rst_n(rst_n), .cal(if0));
  droop_tap_calibrator #(.INIT_WEIGHT(62))  dut1 (.clk(clk), .rst_n(rst_n), .cal(if1));
  droop_tap_calibrator #(.INIT_WEIGHT(-63)) dut2 (.clk(clk), .rst_n(rst_n), .cal(if2));

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] check %s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_w(input string tag, input int e0, input int e1, input int e2);
    chk({tag, " w0"}, int'(if0.tapWeight), e0);
    chk({tag, " w1"}, int'(if1.tapWeight), e1);
    chk({tag, " w2"}, int'(if2.tapWeight), e2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (din_mode == 1) din = din - 16'sd1;
    else if (din_mode == 2) din = din + 16'sd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One triggered pulse; m counts cycles after the edge cycle (m = 0).
  task automatic run_meas(input int retrig_at, input int step_delta,
                          output int lat_o, output int ndone_o, output int busy1_o);
    trig = 1'b1;
    tick();
    lat_o = -1;
    ndone_o = 0;
    busy1_o = 0;
    for (int m = 1; m <= 130; m++) begin
      tick();
      if (m == 1) busy1_o = int'(if0.cal_busy);
      if (m == 3) trig = 1'b0;
      if (retrig_at != 0 && m == retrig_at) trig = 1'b1;
      if (retrig_at != 0 && m == retrig_at + 3) trig = 1'b0;
      if (m == 60) din = din + 16'(step_delta);
      if (if0.cal_done) begin
        ndone_o++;
        if (lat_o < 0) lat_o = m;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; trig = 1'b0; cal_en = 1'b1; din = 16'sd1000; din_mode = 0;
    idle(3);
    chk_w("reset", 0, 62, -63);
    chk("reset busy", int'(if0.cal_busy), 0);
    chk("reset done", int'(if0.cal_done), 0);
    chk("reset sat", int'(if1.weight_sat), 0);
    rst_n = 1'b1;
    idle(4);

    // Flat pulse: no droop, weights hold; latency 1+8+16+64+16.
    run_meas(0, 0, lat, ndone, busy1);
    chk("flat latency", lat, 105);
    chk("flat ndone", ndone, 1);
    chk("flat busy1", busy1, 1);
    chk_w("flat", 0, 62, -63);

    // Falling ramp: diff = -1280, every weight steps up.
    din = 16'sd1000; din_mode = 1;
    run_meas(0, 0, lat, ndone, busy1);
    chk("fall1 ndone", ndone, 1);
    chk_w("fall1", 1, 63, -62);
    chk("fall1 sat1", int'(if1.weight_sat), 0);
    din_mode = 0; idle(60);

    din = 16'sd1000; din_mode = 1;
    run_meas(0, 0, lat, ndone, busy1);
    chk_w("fall2", 2, 63, -61);
    chk("fall2 sat1", int'(if1.weight_sat), 1);
    chk("fall2 sat0", int'(if0.weight_sat), 0);
    din_mode = 0; idle(60);

    din = 16'sd1000; din_mode = 1;
    run_meas(0, 0, lat, ndone, busy1);
    chk_w("fall3", 3, 63, -60);
    chk("fall3 sat1", int'(if1.weight_sat), 1);
    din_mode = 0; idle(10);

    rst_n = 1'b0; idle(2);
    chk("rst2 sat1", int'(if1.weight_sat), 0);
    chk_w("rst2", 0, 62, -63);
    rst_n = 1'b1; idle(4);

    // Rising ramp: diff = +1280, weights step down, w2 clamps at -64.
    din = -16'sd1000; din_mode = 2;
    run_meas(0, 0, lat, ndone, busy1);
    chk_w("rise1", -1, 61, -64);
    chk("rise1 sat2", int'(if2.weight_sat), 0);
    din_mode = 0; idle(60);

    din = -16'sd1000; din_mode = 2;
    run_meas(0, 0, lat, ndone, busy1);
    chk_w("rise2", -2, 60, -64);
    chk("rise2 sat2", int'(if2.weight_sat), 1);
    din_mode = 0; idle(10);

    // Abort in GAP: idle next cycle, no cal_done, weights held.
    din = 16'sd1000; din_mode = 1;
    trig = 1'b1; tick();
    for (int m = 1; m <= 34; m++) begin
      tick();
      if (m == 3) trig = 1'b0;
    end
    chk("gap busy", int'(if0.cal_busy), 1);
    cal_en = 1'b0;
    tick();
    chk("abort busy", int'(if0.cal_busy), 0);
    cnt = 0;
    for (int m = 0; m < 100; m++) begin
      tick();
      if (if0.cal_done) cnt++;
    end
    chk("abort ndone", cnt, 0);
    chk_w("abort", -2, 60, -64);

    // Trigger with calibration disabled never starts a measurement.
    trig = 1'b1; cnt = 0;
    for (int m = 0; m < 10; m++) begin
      tick();
      if (if0.cal_busy) cnt++;
    end
    chk("dis busy", cnt, 0);
    trig = 1'b0; idle(3);
    cal_en = 1'b1; idle(3);

    // Retrigger during WIN_A is ignored: one cal_done at the normal latency.
    din = 16'sd1000; din_mode = 1;
    run_meas(12, 0, lat, ndone, busy1);
    chk("retrig latency", lat, 105);
    chk("retrig ndone", ndone, 1);
    chk_w("retrig", -1, 61, -63);
    din_mode = 0; idle(10);

    // Deadband edges: |diff| = 32 holds, 48 steps.
    din = 16'sd1000;
    run_meas(0, 2, lat, ndone, busy1);
    chk("db+32 ndone", ndone, 1);
    chk_w("db+32", -1, 61, -63);
    din = 16'sd1000;
    run_meas(0, -2, lat, ndone, busy1);
    chk_w("db-32", -1, 61, -63);
    din = 16'sd1000;
    run_meas(0, 3, lat, ndone, busy1);
    chk_w("db+48", -2, 60, -64);
    chk("db+48 sat2", int'(if2.weight_sat), 1);

    // Async reset in WIN_B takes effect without a clock edge.
    din = 16'sd1000; din_mode = 1;
    trig = 1'b1; tick();
    for (int m = 1; m <= 95; m++) begin
      tick();
      if (m == 3) trig = 1'b0;
    end
    chk("winb busy", int'(if0.cal_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async busy", int'(if0.cal_busy), 0);
    chk("async sat2", int'(if2.weight_sat), 0);
    chk_w("async", 0, 62, -63);
    #1;
    rst_n = 1'b1;
    din_mode = 0;
    idle(3);
    chk_w("post", 0, 62, -63);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
